// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the ARM-subset core, plus the NZCV status register.
// Define MC_CTRL_COND_EN to evaluate the condition field; otherwise every instruction executes.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    output logic [2:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  res_src,
    output logic        adr_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic [3:0]  nzcv,
    output logic        illegal
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
        StMemWr, StExecR, StExecI, StAluWb, StBranch
    } state_e;

    state_e     state_q;
    logic [3:0] nzcv_q;

    logic [3:0] cond;
    logic [1:0] op;
    logic       imm_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       is_cmp;
    logic       cmd_legal;
    logic [2:0] cmd_alu_op;
    logic       cond_pass;
    logic       unused_instr;

    assign cond         = instr[31:28];
    assign op           = instr[27:26];
    assign imm_bit      = instr[25];
    assign cmd          = instr[24:21];
    assign s_bit        = instr[20];
    assign is_cmp       = (cmd == 4'b1010);
    assign unused_instr = ^instr[19:0];

    always_comb begin
        cmd_legal  = 1'b1;
        cmd_alu_op = 3'b000;
        unique case (cmd)
            4'b0100: cmd_alu_op = 3'b000;
            4'b0010: cmd_alu_op = 3'b001;
            4'b0000: cmd_alu_op = 3'b010;
            4'b1100: cmd_alu_op = 3'b011;
            4'b1010: cmd_alu_op = 3'b001;
            default: cmd_legal  = 1'b0;
        endcase
    end

`ifdef MC_CTRL_COND_EN
    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;

    always_comb begin
        cond_pass = 1'b0;
        unique case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^cond;
    assign cond_pass   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            nzcv_q  <= 4'b0000;
        end else begin
            unique case (state_q)
                StFetch:  state_q <= StDecode;
                StDecode: begin
                    if (!cond_pass) begin
                        state_q <= StFetch;
                    end else begin
                        unique case (op)
                            2'b01:   state_q <= StMemAdr;
                            2'b00:   state_q <= imm_bit ? StExecI : StExecR;
                            2'b10:   state_q <= StBranch;
                            default: state_q <= StFetch;
                        endcase
                    end
                end
                StMemAdr: state_q <= s_bit ? StMemRd : StMemWr;
                StMemRd:  state_q <= StMemWb;
                StExecR, StExecI: begin
                    if (cmd_legal) begin
                        state_q <= StAluWb;
                        if (s_bit || is_cmp) nzcv_q <= alu_flags;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                default:  state_q <= StFetch;
            endcase
        end
    end

    logic ir_we_raw, pc_we_raw, reg_we_raw, mem_we_raw;

    always_comb begin
        alu_op     = 3'b000;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        res_src    = 2'b00;
        adr_src    = 1'b0;
        ir_we_raw  = 1'b0;
        pc_we_raw  = 1'b0;
        reg_we_raw = 1'b0;
        mem_we_raw = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            StFetch: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                res_src   = 2'b10;
                ir_we_raw = 1'b1;
                pc_we_raw = 1'b1;
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                illegal   = cond_pass && (op == 2'b11);
            end
            StMemAdr: alu_src_b = 2'b01;
            StMemRd:  adr_src = 1'b1;
            StMemWb: begin
                res_src    = 2'b01;
                reg_we_raw = 1'b1;
            end
            StMemWr: begin
                adr_src    = 1'b1;
                mem_we_raw = 1'b1;
            end
            StExecR, StExecI: begin
                alu_op    = cmd_alu_op;
                alu_src_b = (state_q == StExecI) ? 2'b01 : 2'b00;
                illegal   = !cmd_legal;
            end
            StAluWb:  reg_we_raw = !is_cmp;
            StBranch: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                res_src   = 2'b10;
                pc_we_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset directly so an abort kills a write in the same cycle.
    assign ir_we  = ir_we_raw && rst_n;
    assign pc_we  = pc_we_raw && rst_n;
    assign reg_we = reg_we_raw && rst_n;
    assign mem_we = mem_we_raw && rst_n;
    assign nzcv   = nzcv_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle traces derived from the ISA rules.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [3:0]  alu_flags = 4'h0;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src_a, alu_src_b, res_src;
    logic        adr_src, ir_we, pc_we, reg_we, mem_we, illegal;
    logic [3:0]  nzcv;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_flags(alu_flags),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .res_src(res_src), .adr_src(adr_src), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .mem_we(mem_we), .nzcv(nzcv), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [18:0] exp_vec;
    string       exp_name;
    bit          exp_valid = 0;
    logic [3:0]  m_nzcv = 4'h0;
    logic [18:0] act_vec;

    assign act_vec = {alu_op, alu_src_a, alu_src_b, res_src, adr_src,
                      ir_we, pc_we, reg_we, mem_we, illegal, nzcv};

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL step %s: got %b required %b", exp_name, act_vec, exp_vec);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [1:0] o, input logic i,
                                       input logic [3:0] cm, input logic s);
        return {c, o, i, cm, s, 20'h00000};
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
`ifdef MC_CTRL_COND_EN
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            0: return z;         1: return !z;
            2: return cf;        3: return !cf;
            4: return n;         5: return !n;
            6: return v;         7: return !v;
            8: return cf && !z;  9: return !cf || z;
            10: return n == v;   11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1;
            default: return 0;
        endcase
`else
        return (c == c);
`endif
    endfunction

    // ALU operation expected for a data-processing cmd; legal=0 for anything unsupported.
    function automatic logic [2:0] cmd_alu(input logic [3:0] cm, output bit legal);
        legal = 1;
        if (cm == 4'b0100) return 3'd0;
        if (cm == 4'b0010 || cm == 4'b1010) return 3'd1;
        if (cm == 4'b0000) return 3'd2;
        if (cm == 4'b1100) return 3'd3;
        legal = 0;
        return 3'd0;
    endfunction

    function automatic logic [18:0] out_vec(input string st, input logic [31:0] ins,
                                            input bit ill, input logic [3:0] f);
        logic [2:0] aop = 0;
        logic [1:0] a = 0, b = 0, rs = 0;
        logic adr = 0, irw = 0, pcw = 0, rw = 0, mw = 0, il = 0;
        bit legal;
        case (st)
            "F":  begin a = 1; b = 2; rs = 2; irw = 1; pcw = 1; end
            "D":  begin a = 1; b = 2; il = ill; end
            "MA": b = 1;
            "MR": adr = 1;
            "MB": begin rs = 1; rw = 1; end
            "MW": begin adr = 1; mw = 1; end
            "ER", "EI": begin
                aop = cmd_alu(ins[24:21], legal);
                b = (st == "EI") ? 2'd1 : 2'd0;
                il = !legal;
            end
            "WB": rw = (ins[24:21] != 4'b1010);
            "B":  begin a = 1; b = 1; rs = 2; pcw = 1; end
            default: ;
        endcase
        return {aop, a, b, rs, adr, irw, pcw, rw, mw, il, f};
    endfunction

    // Runs one instruction from FETCH; abort_at >= 0 asserts reset inside that step.
    task automatic run(input string name, input logic [31:0] ins, input logic [3:0] fl,
                       input int want_cycles, input int abort_at);
        string steps[$];
        bit legal, ill_dec, upd;
        logic [2:0] unused_op;
        ill_dec = 0;
        upd = 0;
        instr = ins;
        alu_flags = fl;
        steps.push_back("F");
        steps.push_back("D");
        if (cond_ok(ins[31:28], m_nzcv)) begin
            case (ins[27:26])
                2'b01: begin
                    steps.push_back("MA");
                    if (ins[20]) begin steps.push_back("MR"); steps.push_back("MB"); end
                    else steps.push_back("MW");
                end
                2'b00: begin
                    unused_op = cmd_alu(ins[24:21], legal);
                    steps.push_back(ins[25] ? "EI" : "ER");
                    if (legal) begin
                        steps.push_back("WB");
                        upd = ins[20] || (ins[24:21] == 4'b1010);
                    end
                end
                2'b10: steps.push_back("B");
                default: ill_dec = 1;
            endcase
        end
        chk({name, " cycles"}, 8'(steps.size()), 8'(want_cycles));
        for (int i = 0; i < steps.size(); i++) begin
            exp_name = {name, ":", steps[i]};
            exp_vec = out_vec(steps[i], ins, ill_dec, m_nzcv);
            exp_valid = 1;
            if (i == abort_at) begin
                #2;
                chk("mem_we before abort", 8'(mem_we), 8'd1);
                exp_valid = 0;
                rst_n = 0;
                #1;
                chk("mem_we in reset", 8'(mem_we), 8'd0);
                chk("strobes in reset", {4'h0, ir_we, pc_we, reg_we, mem_we}, 8'h00);
                chk("nzcv in reset", 8'(nzcv), 8'h00);
                chk("src_b in reset", 8'(alu_src_b), 8'h02);
                m_nzcv = 0;
                @(posedge clk);
                #2;
                rst_n = 1;
                #1;
                chk("fetch strobes after reset", {6'h0, ir_we, pc_we}, 8'h03);
                return;
            end
            @(posedge clk);
            #1;
            if ((steps[i] == "ER" || steps[i] == "EI") && upd) m_nzcv = fl;
        end
        exp_valid = 0;
    endtask

    localparam bit CE =
`ifdef MC_CTRL_COND_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        @(posedge clk);
        #1;
        chk("reset ir_we", 8'(ir_we), 8'd0);
        chk("reset pc_we", 8'(pc_we), 8'd0);
        chk("reset nzcv", 8'(nzcv), 8'd0);
        chk("reset illegal", 8'(illegal), 8'd0);
        chk("reset src_a", 8'(alu_src_a), 8'd1);
        #2;
        rst_n = 1;
        #1;
        chk("first fetch strobes", {6'h0, ir_we, pc_we}, 8'h03);

        run("ADD",   mk(4'hE, 2'b00, 1'b0, 4'b0100, 1'b0), 4'b1111, 4, -1);
        chk("ADD keeps nzcv", 8'(nzcv), 8'h00);
        run("SUBS",  mk(4'hE, 2'b00, 1'b1, 4'b0010, 1'b1), 4'b0011, 4, -1);
        run("CMP",   mk(4'hE, 2'b00, 1'b1, 4'b1010, 1'b0), 4'b0100, 4, -1);
        chk("CMP sets nzcv", 8'(nzcv), 8'h04);
        run("BEQ1",  mk(4'h0, 2'b10, 1'b0, 4'b0000, 1'b0), 4'b0000, 3, -1);
        run("CMP0",  mk(4'hE, 2'b00, 1'b1, 4'b1010, 1'b1), 4'b0000, 4, -1);
        run("BEQ2",  mk(4'h0, 2'b10, 1'b0, 4'b0000, 1'b0), 4'b0000, CE ? 2 : 3, -1);
        run("LDR",   mk(4'hE, 2'b01, 1'b0, 4'b0000, 1'b1), 4'b0000, 5, -1);
        run("OP11",  mk(4'hE, 2'b11, 1'b0, 4'b0000, 1'b0), 4'b0000, 2, -1);
        run("BADCMD", mk(4'hE, 2'b00, 1'b0, 4'b0001, 1'b1), 4'b1111, 3, -1);
        chk("bad cmd keeps nzcv", 8'(nzcv), 8'h00);
        run("ORRS",  mk(4'hE, 2'b00, 1'b0, 4'b1100, 1'b1), 4'b1001, 4, -1);
        chk("ORRS sets nzcv", 8'(nzcv), 8'h09);
        run("BGE",   mk(4'hA, 2'b10, 1'b0, 4'b0000, 1'b0), 4'b0000, 3, -1);
        run("BLT",   mk(4'hB, 2'b10, 1'b0, 4'b0000, 1'b0), 4'b0000, CE ? 2 : 3, -1);
        run("ANDNV", mk(4'hF, 2'b00, 1'b1, 4'b0000, 1'b1), 4'b0110, CE ? 2 : 4, -1);
        run("BHI",   mk(4'h8, 2'b10, 1'b0, 4'b0000, 1'b0), 4'b0000, CE ? 2 : 3, -1);
        run("STR",   mk(4'hE, 2'b01, 1'b0, 4'b0000, 1'b0), 4'b0000, 4, -1);
        run("STRABT", mk(4'hE, 2'b01, 1'b0, 4'b0000, 1'b0), 4'b0000, 4, 3);
        run("ADD2",  mk(4'hE, 2'b00, 1'b0, 4'b0100, 1'b0), 4'b0101, 4, -1);
        chk("nzcv after abort", 8'(nzcv), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
